wash_input_conditioner: RTL and testbench

Front-end stage that feeds the car-wash sequencer. It takes raw board buttons and program switches, then:
- synchronises and debounces them;
- turns the advance and cancel buttons into single-cycle pulses;
- decodes the three program switches into a program code;
- freezes that code while a wash is in progress.
The sequencer consumes adv_pulse, cancel_pulse and prog_sel, and returns wash_idle.

---
 rtl/wash_pkg.sv | 50 +++++
 rtl/wash_debounce.sv | 54 +++++
 rtl/wash_input_conditioner.sv | 124 ++++++++++++
 tb/tb_wash_input_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// wash_pkg: definitions shared by the car-wash input conditioner and the
// sequencer.
//   prog_t       - program codes that travel on prog_sel
//   wash_state_t - TRACK/LOCK state encoding of the program-freeze FSM
//   SW_*         - bit positions of the program switches in sw_prog_raw
//   IN_*         - positions of each conditioned input in the debounce bank
//   prog_decode  - one-hot switch pattern to program code
//   prog_multi   - 1 when more than one program switch is on
package wash_pkg;

    typedef enum logic [1:0] {
        PROG_NONE  = 2'd0,
        PROG_BASIC = 2'd1,
        PROG_EXTRA = 2'd2,
        PROG_PLAT  = 2'd3
    } prog_t;

    typedef enum logic {
        TRACK = 1'b0,
        LOCK  = 1'b1
    } wash_state_t;

    localparam int SW_BASIC = 2;
    localparam int SW_EXTRA = 1;
    localparam int SW_PLAT  = 0;

    // Debounce bank layout: {sw[2:0], cancel, adv}
    localparam int IN_ADV    = 0;
    localparam int IN_CANCEL = 1;
    localparam int IN_SW_LO  = 2;
    localparam int N_INPUTS  = 5;

    function automatic prog_t prog_decode(input logic [2:0] sw);
        prog_t code;
        code = PROG_NONE;
        if (sw[SW_BASIC] && !sw[SW_EXTRA] && !sw[SW_PLAT]) begin
            code = PROG_BASIC;
        end else if (!sw[SW_BASIC] && sw[SW_EXTRA] && !sw[SW_PLAT]) begin
            code = PROG_EXTRA;
        end else if (!sw[SW_BASIC] && !sw[SW_EXTRA] && sw[SW_PLAT]) begin
            code = PROG_PLAT;
        end
        return code;
    endfunction

    function automatic logic prog_multi(input logic [2:0] sw);
        return (sw[0] & sw[1]) | (sw[0] & sw[2]) | (sw[1] & sw[2]);
    endfunction

endpackage

// File: rtl/wash_debounce.sv
// wash_debounce: synchroniser plus debounce counter for one raw input bit.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   raw_i   - asynchronous raw input
//   level_o - debounced level; follows raw_i only after the synchronised
//             value has disagreed with it for DEBOUNCE_CYCLES straight cycles
module wash_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    // Any cycle of agreement restarts the count, so a glitch has to last the
    // whole window to be accepted.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_input_conditioner.sv
// wash_input_conditioner: front end of the car-wash sequencer.
// Debounces the buttons and program switches, converts button presses into
// one-cycle pulses, decodes the program switches and freezes the program
// code while a wash is running.
//   clk, rst        - clock, synchronous active-high reset
//   btn_adv_raw     - raw advance/start button
//   btn_cancel_raw  - raw cancel button
//   sw_prog_raw     - raw program switches [2]=basic [1]=extra [0]=platinum
//   wash_idle       - sequencer is idle
//   adv_pulse       - accepted advance request (1 cycle)
//   cancel_pulse    - cancel request (1 cycle)
//   prog_sel        - program code (frozen while LOCK)
//   prog_err        - more than one debounced program switch on
//   adv_reject      - start press dropped for lack of a valid program (1 cycle)
module wash_input_conditioner
    import wash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_adv_raw,
    input  logic       btn_cancel_raw,
    input  logic [2:0] sw_prog_raw,
    input  logic       wash_idle,
    output logic       adv_pulse,
    output logic       cancel_pulse,
    output logic [1:0] prog_sel,
    output logic       prog_err,
    output logic       adv_reject
);

    logic [N_INPUTS-1:0] raw_vec;
    logic [N_INPUTS-1:0] lvl_vec;

    assign raw_vec = {sw_prog_raw, btn_cancel_raw, btn_adv_raw};

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_db
            wash_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_db (
                .clk     (clk),
                .rst     (rst),
                .raw_i   (raw_vec[gi]),
                .level_o (lvl_vec[gi])
            );
        end
    endgenerate

    logic [2:0]  sw_db;
    prog_t       prog_dec;
    logic        adv_evt, cancel_evt, adv_only, idle_rise;

    wash_state_t state_q;
    prog_t       prog_sel_q;
    logic        adv_lvl_q, cancel_lvl_q, idle_q;
    logic        adv_pulse_q, cancel_pulse_q, adv_reject_q;

    assign sw_db      = lvl_vec[IN_SW_LO +: 3];
    assign prog_dec   = prog_decode(sw_db);
    assign adv_evt    = lvl_vec[IN_ADV] & ~adv_lvl_q;
    assign cancel_evt = lvl_vec[IN_CANCEL] & ~cancel_lvl_q;
    // Cancel wins a same-cycle collision; the advance is dropped silently.
    assign adv_only   = adv_evt & ~cancel_evt;
    // idle_q powers up at 1 so the first idle cycle after reset is not an edge.
    assign idle_rise  = wash_idle & ~idle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= TRACK;
            prog_sel_q     <= PROG_NONE;
            adv_lvl_q      <= 1'b0;
            cancel_lvl_q   <= 1'b0;
            idle_q         <= 1'b1;
            adv_pulse_q    <= 1'b0;
            cancel_pulse_q <= 1'b0;
            adv_reject_q   <= 1'b0;
        end else begin
            adv_lvl_q      <= lvl_vec[IN_ADV];
            cancel_lvl_q   <= lvl_vec[IN_CANCEL];
            idle_q         <= wash_idle;
            adv_pulse_q    <= 1'b0;
            adv_reject_q   <= 1'b0;
            cancel_pulse_q <= cancel_evt;
            case (state_q)
                TRACK: begin
                    prog_sel_q <= prog_dec;
                    if (adv_only) begin
                        if (!wash_idle) begin
                            // Sequencer mid-run: pass the step request through.
                            adv_pulse_q <= 1'b1;
                        end else if (prog_dec != PROG_NONE) begin
                            adv_pulse_q <= 1'b1;
                            state_q     <= LOCK;
                        end else begin
                            adv_reject_q <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (adv_only) begin
                        adv_pulse_q <= 1'b1;
                    end
                    if (cancel_evt || idle_rise) begin
                        state_q <= TRACK;
                    end
                end
                default: state_q <= TRACK;
            endcase
        end
    end

    assign adv_pulse    = adv_pulse_q;
    assign cancel_pulse = cancel_pulse_q;
    assign adv_reject   = adv_reject_q;
    assign prog_sel     = prog_sel_q;
    assign prog_err     = prog_multi(sw_db);

endmodule

// File: tb/tb_wash_input_conditioner.sv
// Directed bench for wash_input_conditioner with a short debounce window.
// A behavioural model predicts every output after every clock edge; literal
// expectations at the end of each scenario pin the model itself.
module tb_wash_input_conditioner;

    localparam int DB = 4;
    localparam int SS = 2;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_adv_raw, btn_cancel_raw, wash_idle;
    logic [2:0] sw_prog_raw;
    logic       adv_pulse, cancel_pulse, prog_err, adv_reject;
    logic [1:0] prog_sel;

    always #5 clk = ~clk;

    wash_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_adv_raw    (btn_adv_raw),
        .btn_cancel_raw (btn_cancel_raw),
        .sw_prog_raw    (sw_prog_raw),
        .wash_idle      (wash_idle),
        .adv_pulse      (adv_pulse),
        .cancel_pulse   (cancel_pulse),
        .prog_sel       (prog_sel),
        .prog_err       (prog_err),
        .adv_reject     (adv_reject)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int n_adv, n_can, n_rej, last_adv_cyc;

    // Model state: raw samples since reset, accepted levels, disagreement
    // run lengths, and the sequencer-facing view (locked / frozen program).
    bit [4:0] hist[$];
    bit [4:0] lvl;
    int       run[5];
    bit       adv_rose, can_rose, last_idle, locked;
    bit [1:0] m_prog;
    bit       m_adv, m_can, m_rej, m_err;

    function automatic bit [1:0] decode(input bit [2:0] s);
        int ones;
        ones = int'(s[0]) + int'(s[1]) + int'(s[2]);
        if (ones != 1) return 2'd0;
        if (s[2]) return 2'd1;
        if (s[1]) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
        end
    endtask

    // Called just after a rising edge; inputs still hold the sampled values.
    task automatic model_edge();
        bit [4:0] raw_now, synced;
        bit [1:0] code;
        bit       adv_evt, can_evt, rise;
        raw_now = {sw_prog_raw, btn_cancel_raw, btn_adv_raw};
        if (rst) begin
            hist.delete();
            lvl = '0;
            for (int b = 0; b < 5; b++) run[b] = 0;
            adv_rose = 0; can_rose = 0; last_idle = 1; locked = 0;
            m_prog = 0; m_adv = 0; m_can = 0; m_rej = 0; m_err = 0;
            return;
        end
        // Events come from levels accepted at the previous edge.
        adv_evt = adv_rose;
        can_evt = can_rose;
        code    = decode(lvl[4:2]);
        rise    = wash_idle && !last_idle;
        last_idle = wash_idle;
        m_adv = 0; m_rej = 0; m_can = can_evt;
        if (!locked) begin
            m_prog = code;
            if (adv_evt && !can_evt) begin
                if (!wash_idle) m_adv = 1;
                else if (code != 0) begin m_adv = 1; locked = 1; end
                else m_rej = 1;
            end
        end else begin
            m_adv = adv_evt && !can_evt;
            if (can_evt || rise) locked = 0;
        end
        // A raw sample reaches the debouncer SS edges after it was taken.
        synced = (hist.size() >= SS) ? hist[hist.size() - SS] : 5'b0;
        hist.push_back(raw_now);
        if (hist.size() > SS) void'(hist.pop_front());
        adv_rose = 0; can_rose = 0;
        for (int b = 0; b < 5; b++) begin
            if (synced[b] != lvl[b]) begin
                run[b]++;
                if (run[b] == DB) begin
                    lvl[b] = synced[b];
                    run[b] = 0;
                    if (synced[b] && b == 0) adv_rose = 1;
                    if (synced[b] && b == 1) can_rose = 1;
                end
            end else begin
                run[b] = 0;
            end
        end
        m_err = (int'(lvl[2]) + int'(lvl[3]) + int'(lvl[4])) > 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        cyc_n++;
        #2;
        check("adv_pulse",    int'(adv_pulse),    int'(m_adv));
        check("cancel_pulse", int'(cancel_pulse), int'(m_can));
        check("adv_reject",   int'(adv_reject),   int'(m_rej));
        check("prog_sel",     int'(prog_sel),     int'(m_prog));
        check("prog_err",     int'(prog_err),     int'(m_err));
        if (adv_pulse)    begin n_adv++; last_adv_cyc = cyc_n; end
        if (cancel_pulse) n_can++;
        if (adv_reject)   n_rej++;
        if (adv_pulse || cancel_pulse || adv_reject)
            $display("cycle %0d adv=%0d cancel=%0d reject=%0d prog_sel=%0d",
                     cyc_n, adv_pulse, cancel_pulse, adv_reject, prog_sel);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int start;

    initial begin
        rst = 1; btn_adv_raw = 0; btn_cancel_raw = 0; sw_prog_raw = 3'b000; wash_idle = 0;
        n_adv = 0; n_can = 0; n_rej = 0; last_adv_cyc = 0;
        wait_cycles(3);
        check("reset_prog_sel", int'(prog_sel), 0);
        check("reset_adv_pulse", int'(adv_pulse), 0);
        rst = 0;
        wait_cycles(2);

        // 1. Debounce: 3-cycle bursts never pass, a held press gives one pulse.
        for (int k = 0; k < 3; k++) begin
            btn_adv_raw = 1; wait_cycles(3);
            btn_adv_raw = 0; wait_cycles(3);
        end
        wait_cycles(6);
        check("burst_no_pulse", n_adv, 0);
        btn_adv_raw = 1; start = cyc_n;
        wait_cycles(8);
        check("hold_pulse_count", n_adv, 1);
        check("hold_pulse_latency", last_adv_cyc - start, 7);
        wait_cycles(20);
        check("hold_no_repeat", n_adv, 1);
        btn_adv_raw = 0; wait_cycles(8);
        check("release_no_pulse", n_adv, 1);

        // 2. Start with basic program, then switch changes are ignored.
        wash_idle = 1; sw_prog_raw = 3'b100; wait_cycles(8);
        check("basic_decoded", int'(prog_sel), 1);
        n_adv = 0;
        btn_adv_raw = 1; wait_cycles(8);
        check("start_pulse", n_adv, 1);
        btn_adv_raw = 0; wait_cycles(8);
        sw_prog_raw = 3'b001; wait_cycles(8);
        check("lock_holds_prog", int'(prog_sel), 1);

        // Cancel alone returns to TRACK; program follows switches again.
        n_can = 0;
        btn_cancel_raw = 1; wait_cycles(8);
        check("cancel_count", n_can, 1);
        check("cancel_unlocks", int'(prog_sel), 3);
        btn_cancel_raw = 0; wait_cycles(8);

        // 3. Two switches on: error flag, start press rejected.
        sw_prog_raw = 3'b011; wait_cycles(8);
        check("multi_err", int'(prog_err), 1);
        check("multi_prog_none", int'(prog_sel), 0);
        n_adv = 0; n_rej = 0;
        btn_adv_raw = 1; wait_cycles(8);
        check("reject_count", n_rej, 1);
        check("reject_no_adv", n_adv, 0);
        btn_adv_raw = 0; wait_cycles(8);

        // 4. Lock on platinum, unlock on wash_idle rising.
        sw_prog_raw = 3'b001; wait_cycles(8);
        btn_adv_raw = 1; wait_cycles(8);
        btn_adv_raw = 0; wait_cycles(8);
        check("plat_locked", int'(prog_sel), 3);
        wash_idle = 0; wait_cycles(10);
        wash_idle = 1; wait_cycles(2);
        sw_prog_raw = 3'b010; wait_cycles(8);
        check("unlock_follows", int'(prog_sel), 2);

        // 5. Collision in LOCK: cancel wins, advance dropped, back to TRACK.
        btn_adv_raw = 1; wait_cycles(8);
        btn_adv_raw = 0; wait_cycles(8);
        n_adv = 0; n_can = 0; n_rej = 0;
        btn_adv_raw = 1; btn_cancel_raw = 1; wait_cycles(8);
        check("collide_cancel", n_can, 1);
        check("collide_no_adv", n_adv, 0);
        check("collide_no_reject", n_rej, 0);
        sw_prog_raw = 3'b001; wait_cycles(8);
        check("collide_tracking", int'(prog_sel), 3);
        btn_adv_raw = 0; btn_cancel_raw = 0; wait_cycles(8);

        // 6. Reset mid-count while locked with a still-held button.
        sw_prog_raw = 3'b010; wait_cycles(8);
        btn_adv_raw = 1; wait_cycles(8);
        btn_adv_raw = 0; wait_cycles(8);
        check("extra_locked", int'(prog_sel), 2);
        btn_adv_raw = 1; wait_cycles(3);
        rst = 1; cyc();
        check("rst_prog_sel", int'(prog_sel), 0);
        check("rst_adv", int'(adv_pulse), 0);
        check("rst_cancel", int'(cancel_pulse), 0);
        check("rst_err", int'(prog_err), 0);
        check("rst_reject", int'(adv_reject), 0);
        rst = 0; start = cyc_n; n_adv = 0;
        wait_cycles(12);
        // Debounced level re-accepted 6 cycles after reset, pulse registered one later.
        check("post_rst_pulse_count", n_adv, 1);
        check("post_rst_latency", last_adv_cyc - start, 7);
        check("post_rst_relock", int'(prog_sel), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
